// File: rtl/sync_ptr_gray_pkg.sv
// sync_pkg: Gray decode and popcount helpers (operands zero-extended to SYNC_W_MAX bits) plus legal synchronizer depth range
package sync_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 6;
  localparam int SYNC_W_MAX = 32;
  function automatic logic [SYNC_W_MAX-1:0] gray2bin(input logic [SYNC_W_MAX-1:0] g);
    logic [SYNC_W_MAX-1:0] b;
    b = g;
    for (int i = 1; i < SYNC_W_MAX; i++) b ^= g >> i;
    return b;
  endfunction
  function automatic int unsigned popcount(input logic [SYNC_W_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < SYNC_W_MAX; i++) c += 32'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/sync_ptr_gray_chain.sv
// sync_chain: STAGES-deep flop chain (clk_i, rst_ni async active-low, d_i -> q_o), usable for pointers or single-bit flags
module sync_chain import sync_pkg::*; #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_chain: STAGES below minimum");
  end
  logic [STAGES-1:0][WIDTH-1:0] stg;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) stg <= '0;
    else stg <= {stg[STAGES-2:0], d_i};
  assign q_o = stg[STAGES-1];
endmodule

// File: rtl/sync_ptr_gray.sv
// sync_ptr_gray: Gray pointer CDC into dclk_i with binary decode, change pulse, delta and valid; SYNC_PTR_GRAY_CHECK_EN adds sticky gray_err_o (cleared by err_clr_i)
module sync_ptr_gray import sync_pkg::*; #(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2
) (
  input  logic              dclk_i,
  input  logic              drst_ni,
  input  logic [ADDRSIZE:0] ptr_gray_i,
  input  logic              err_clr_i,
  output logic [ADDRSIZE:0] ptr_gray_o,
  output logic [ADDRSIZE:0] ptr_bin_o,
  output logic              ptr_chg_o,
  output logic [ADDRSIZE:0] ptr_delta_o,
  output logic              sync_vld_o,
  output logic              gray_err_o
);
  localparam int W = ADDRSIZE + 1;
  localparam int CW = $clog2(STAGES + 2);
  localparam logic [CW-1:0] FULL = CW'(STAGES + 1);
  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_ptr_gray: STAGES out of range 2..6");
  end
  if (W > SYNC_W_MAX) begin : g_bad_width
    $error("sync_ptr_gray: ADDRSIZE too large");
  end
  logic [W-1:0] bin_nxt;
  logic [CW-1:0] fill;
  logic chg_nxt;
  sync_chain #(.WIDTH(W), .STAGES(STAGES)) u_chain (
    .clk_i (dclk_i),
    .rst_ni(drst_ni),
    .d_i   (ptr_gray_i),
    .q_o   (ptr_gray_o)
  );
  assign bin_nxt = W'(gray2bin(SYNC_W_MAX'(ptr_gray_o)));
  assign sync_vld_o = fill == FULL;
  assign chg_nxt = sync_vld_o && bin_nxt != ptr_bin_o;
  always_ff @(posedge dclk_i or negedge drst_ni)
    if (!drst_ni) begin
      fill        <= '0;
      ptr_bin_o   <= '0;
      ptr_chg_o   <= 1'b0;
      ptr_delta_o <= '0;
    end else begin
      fill        <= sync_vld_o ? fill : fill + 1'b1;
      ptr_bin_o   <= bin_nxt;
      ptr_chg_o   <= chg_nxt;
      ptr_delta_o <= chg_nxt ? bin_nxt - ptr_bin_o : ptr_delta_o;
    end
`ifdef SYNC_PTR_GRAY_CHECK_EN
  logic [W-1:0] gray_prev;
  always_ff @(posedge dclk_i or negedge drst_ni)
    if (!drst_ni) begin
      gray_prev  <= '0;
      gray_err_o <= 1'b0;
    end else begin
      gray_prev  <= ptr_gray_o;
      gray_err_o <= (sync_vld_o && popcount(SYNC_W_MAX'(ptr_gray_o ^ gray_prev)) > 1) || (gray_err_o && !err_clr_i);
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign gray_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sync_ptr_gray.sv
// tb_sync_ptr_gray: randomized and directed checks of sync_ptr_gray against a history-based reference model
module tb_sync_ptr_gray;
  localparam int AW = 4;
  localparam int W = AW + 1;
  localparam int S0 = 2;
  localparam int S1 = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n = 1'b1, rst1_n = 1'b1, clr0 = 1'b0, clr1 = 1'b0;
  logic [W-1:0] in0 = '0, in1 = '0;
  logic [W-1:0] g0, b0, d0, g1, b1, d1;
  logic chg0, vld0, err0, chg1, vld1, err1;
  int checks = 0, errors = 0;
  int n = 0;
  logic [W-1:0] hist [0:4095];
  logic [W-1:0] m_bin, m_delta;
  logic m_chg, m_vld, m_err;
  sync_ptr_gray #(.ADDRSIZE(AW), .STAGES(S0)) dut0 (
    .dclk_i(clk), .drst_ni(rst0_n), .ptr_gray_i(in0), .err_clr_i(clr0),
    .ptr_gray_o(g0), .ptr_bin_o(b0), .ptr_chg_o(chg0), .ptr_delta_o(d0),
    .sync_vld_o(vld0), .gray_err_o(err0)
  );
  sync_ptr_gray #(.ADDRSIZE(AW), .STAGES(S1)) dut1 (
    .dclk_i(clk), .drst_ni(rst1_n), .ptr_gray_i(in1), .err_clr_i(clr1),
    .ptr_gray_o(g1), .ptr_bin_o(b1), .ptr_chg_o(chg1), .ptr_delta_o(d1),
    .sync_vld_o(vld1), .gray_err_o(err1)
  );
  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic int ones(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) if (v[i]) c++;
    return c;
  endfunction
  function automatic logic [W-1:0] gout(input int k);
    return (k - S0 + 1 >= 1) ? to_gray(hist[k-S0+1]) : '0;
  endfunction
  function automatic logic exp_err();
`ifdef SYNC_PTR_GRAY_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction
  task automatic model_reset();
    n = 0; m_bin = '0; m_delta = '0; m_chg = 1'b0; m_vld = 1'b0; m_err = 1'b0;
  endtask
  task automatic model_edge(input logic [W-1:0] b, input logic clr);
    logic [W-1:0] nb;
    n++;
    hist[n] = b;
    nb = (n > S0) ? hist[n-S0] : '0;
    if (m_vld && ones(gout(n-1) ^ gout(n-2)) > 1) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_chg = m_vld && nb != m_bin;
    if (m_chg) m_delta = nb - m_bin;
    m_bin = nb;
    m_vld = n >= S0 + 1;
  endtask
  task automatic step(input int unsigned b, input logic clr);
    @(negedge clk);
    in0 = to_gray(W'(b));
    clr0 = clr;
    @(posedge clk);
    model_edge(W'(b), clr);
    #1;
  endtask
  task automatic test_reset();
    #1 rst0_n = 1'b0; rst1_n = 1'b0; model_reset();
    #1;
    checks++; if ({g0, b0, d0, chg0, vld0, err0} !== '0) begin errors++; $display("FAIL reset_state got %0h want 0", {g0, b0, d0, chg0, vld0, err0}); end
    @(posedge clk);
    #2 rst0_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(0, 1'b0);
      checks++; if (g0 !== gout(n)) begin errors++; $display("FAIL reset_fill gray got %0h want %0h", g0, gout(n)); end
      checks++; if (b0 !== m_bin) begin errors++; $display("FAIL reset_fill bin got %0d want %0d", b0, m_bin); end
      checks++; if (chg0 !== m_chg) begin errors++; $display("FAIL reset_fill chg got %0b want %0b", chg0, m_chg); end
      checks++; if (d0 !== m_delta) begin errors++; $display("FAIL reset_fill delta got %0d want %0d", d0, m_delta); end
      checks++; if (vld0 !== m_vld) begin errors++; $display("FAIL reset_fill vld got %0b want %0b", vld0, m_vld); end
      checks++; if (vld0 !== (i >= 3)) begin errors++; $display("FAIL vld_edge edge %0d got %0b want %0b", i, vld0, i >= 3); end
    end
  endtask
  task automatic test_gray_steps();
    int pulses;
    pulses = 0;
    for (int s = 1; s <= 3; s++)
      for (int c = 0; c < 4; c++) begin
        step(s, 1'b0);
        checks++; if (b0 !== m_bin) begin errors++; $display("FAIL steps bin got %0d want %0d", b0, m_bin); end
        checks++; if (chg0 !== m_chg) begin errors++; $display("FAIL steps chg got %0b want %0b", chg0, m_chg); end
        checks++; if (d0 !== m_delta) begin errors++; $display("FAIL steps delta got %0d want %0d", d0, m_delta); end
        checks++; if (err0 !== exp_err()) begin errors++; $display("FAIL steps err got %0b want %0b", err0, exp_err()); end
        if (chg0) begin
          pulses++;
          checks++; if (d0 !== W'(1)) begin errors++; $display("FAIL steps unit_delta got %0d want 1", d0); end
        end
      end
    checks++; if (pulses != 3) begin errors++; $display("FAIL steps pulses got %0d want 3", pulses); end
    checks++; if (b0 !== W'(3)) begin errors++; $display("FAIL steps final_bin got %0d want 3", b0); end
  endtask
  task automatic test_wrap();
    int pulses;
    for (int c = 0; c < 4; c++) step(30, 1'b0);
    checks++; if (b0 !== W'(30)) begin errors++; $display("FAIL wrap pre_bin got %0d want 30", b0); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step(2, 1'b0);
      checks++; if (b0 !== m_bin) begin errors++; $display("FAIL wrap bin got %0d want %0d", b0, m_bin); end
      checks++; if (chg0 !== m_chg) begin errors++; $display("FAIL wrap chg got %0b want %0b", chg0, m_chg); end
      checks++; if (d0 !== m_delta) begin errors++; $display("FAIL wrap delta got %0d want %0d", d0, m_delta); end
      if (chg0) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL wrap pulses got %0d want 1", pulses); end
    checks++; if (d0 !== W'(4)) begin errors++; $display("FAIL wrap final_delta got %0d want 4", d0); end
  endtask
  task automatic test_random();
    int unsigned cur;
    cur = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) cur = (cur + $urandom_range(1, 7)) % 32;
      step(cur, $urandom_range(0, 7) == 0);
      checks++; if (g0 !== gout(n)) begin errors++; $display("FAIL random gray got %0h want %0h", g0, gout(n)); end
      checks++; if (b0 !== m_bin) begin errors++; $display("FAIL random bin got %0d want %0d", b0, m_bin); end
      checks++; if (chg0 !== m_chg) begin errors++; $display("FAIL random chg got %0b want %0b", chg0, m_chg); end
      checks++; if (d0 !== m_delta) begin errors++; $display("FAIL random delta got %0d want %0d", d0, m_delta); end
      checks++; if (vld0 !== m_vld) begin errors++; $display("FAIL random vld got %0b want %0b", vld0, m_vld); end
      checks++; if (err0 !== exp_err()) begin errors++; $display("FAIL random err got %0b want %0b", err0, exp_err()); end
    end
  endtask
  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) step(9, 1'b0);
    checks++; if (b0 !== W'(9)) begin errors++; $display("FAIL mid pre_bin got %0d want 9", b0); end
    #1 rst0_n = 1'b0; model_reset();
    #1;
    checks++; if ({g0, b0, d0, chg0, vld0, err0} !== '0) begin errors++; $display("FAIL mid async_clear got %0h want 0", {g0, b0, d0, chg0, vld0, err0}); end
    #1 rst0_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(9, 1'b0);
      checks++; if (b0 !== m_bin) begin errors++; $display("FAIL mid bin got %0d want %0d", b0, m_bin); end
      checks++; if (vld0 !== m_vld) begin errors++; $display("FAIL mid vld got %0b want %0b", vld0, m_vld); end
      checks++; if (chg0 !== 1'b0) begin errors++; $display("FAIL mid no_pulse got %0b want 0", chg0); end
      checks++; if (d0 !== '0) begin errors++; $display("FAIL mid delta got %0d want 0", d0); end
    end
    checks++; if (b0 !== W'(9)) begin errors++; $display("FAIL mid final_bin got %0d want 9", b0); end
  endtask
  task automatic test_stages4();
    in1 = to_gray(W'(5));
    @(posedge clk);
    #2 rst1_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      checks++; if (g1 !== ((e >= 4) ? to_gray(W'(5)) : '0)) begin errors++; $display("FAIL s4 gray edge %0d got %0h", e, g1); end
      checks++; if (b1 !== ((e >= 5) ? W'(5) : '0)) begin errors++; $display("FAIL s4 bin edge %0d got %0d want %0d", e, b1, (e >= 5) ? 5 : 0); end
      checks++; if (vld1 !== (e >= 5)) begin errors++; $display("FAIL s4 vld edge %0d got %0b want %0b", e, vld1, e >= 5); end
      checks++; if (chg1 !== 1'b0 || d1 !== '0 || err1 !== 1'b0) begin errors++; $display("FAIL s4 quiet edge %0d got chg %0b delta %0d err %0b want 0", e, chg1, d1, err1); end
    end
  endtask
  task automatic test_gray_err();
    @(posedge clk);
    #2 rst0_n = 1'b0; in0 = '0; clr0 = 1'b0; model_reset();
    #1 rst0_n = 1'b1;
    for (int c = 0; c < 4; c++) step(0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(6, 1'b0);
      checks++; if (err0 !== exp_err()) begin errors++; $display("FAIL err set got %0b want %0b", err0, exp_err()); end
      checks++; if (b0 !== m_bin) begin errors++; $display("FAIL err bin got %0d want %0d", b0, m_bin); end
    end
`ifdef SYNC_PTR_GRAY_CHECK_EN
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err sticky got %0b want 1", err0); end
`else
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err tied got %0b want 0", err0); end
`endif
    step(4, 1'b0);
    step(4, 1'b0);
    step(4, 1'b1);
    checks++; if (err0 !== exp_err()) begin errors++; $display("FAIL err set_wins got %0b want %0b", err0, exp_err()); end
`ifdef SYNC_PTR_GRAY_CHECK_EN
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err set_wins_const got %0b want 1", err0); end
`endif
    step(4, 1'b0);
    checks++; if (err0 !== exp_err()) begin errors++; $display("FAIL err hold got %0b want %0b", err0, exp_err()); end
    step(4, 1'b1);
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err clear got %0b want 0", err0); end
    step(4, 1'b0);
    checks++; if (err0 !== exp_err()) begin errors++; $display("FAIL err after_clear got %0b want %0b", err0, exp_err()); end
  endtask
  initial begin
    test_reset();
    test_gray_steps();
    test_wrap();
    test_random();
    test_reset_mid();
    test_stages4();
    test_gray_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_ptr_gray.md
Name: sync_ptr_gray

Overview:
- Parametrised successor to the two-flop pointer synchronizer.
- Carries a Gray-coded FIFO pointer from a source domain into the destination domain through a configurable N-stage flop chain.
- Adds a registered binary decode, a change pulse, the pointer advance (delta) since the last update, and a post-reset valid flag.
- Instantiated on the write side (read pointer) and the read side (write pointer) of the I2C async FIFOs.

Parameters:
- ADDRSIZE, 4, FIFO address width; the pointer is ADDRSIZE+1 bits (includes the wrap bit).
- STAGES, 2, number of synchronizer flops; legal range 2..6. Elaboration error outside this range.

Ports:
- dclk_i  input  1  destination-domain clock
- drst_ni  input  1  destination-domain reset; asynchronous assert, active-low
- ptr_gray_i  input  ADDRSIZE+1  Gray pointer from the source domain (asynchronous to dclk_i)
- err_clr_i  input  1  clears gray_err_o (used only with the optional feature)
- ptr_gray_o  output  ADDRSIZE+1  synchronized Gray pointer (last chain stage)
- ptr_bin_o  output  ADDRSIZE+1  registered binary decode of ptr_gray_o
- ptr_chg_o  output  1  one-cycle pulse when ptr_bin_o takes a new value
- ptr_delta_o  output  ADDRSIZE+1  (new ptr_bin_o - previous ptr_bin_o) mod 2^(ADDRSIZE+1); held between changes
- sync_vld_o  output  1  high once the chain has been refilled after reset
- gray_err_o  output  1  sticky Gray-code violation flag (optional feature)

Behaviour:
- Clocking: one clock, dclk_i. Reset is asynchronous and active-low on drst_ni.
- Reset: all chain stages, ptr_gray_o, ptr_bin_o and ptr_delta_o go to 0. ptr_chg_o, sync_vld_o and gray_err_o go to 0. The fill counter goes to 0.
- Chain: on every dclk_i rising edge, stage[0] <= ptr_gray_i and stage[k] <= stage[k-1]. ptr_gray_o = stage[STAGES-1].
- Chain latency: STAGES edges from input sampling to ptr_gray_o.
- Decode: ptr_bin_o <= gray2bin(ptr_gray_o), giving STAGES+1 edges total latency. gray2bin: bin[MSB] = g[MSB]; bin[i] = bin[i+1] ^ g[i].
- Change and delta: on the same edge that ptr_bin_o updates:
  - ptr_chg_o <= sync_vld_o && (gray2bin(ptr_gray_o) != ptr_bin_o)
  - ptr_delta_o <= gray2bin(ptr_gray_o) - ptr_bin_o, unsigned, truncated to ADDRSIZE+1 bits.
  - ptr_delta_o loads only when the change condition is true; otherwise it holds.
- Wrap-around: delta arithmetic is modulo 2^(ADDRSIZE+1). Example: bin 31 -> 1 with ADDRSIZE=4 gives delta 2.
- Fill counter: counts dclk_i edges after reset deassertion and saturates at STAGES+1. sync_vld_o is asserted from the edge on which the count reaches STAGES+1.
  - Before sync_vld_o: ptr_chg_o is suppressed and ptr_delta_o holds 0. ptr_bin_o still tracks.
- Reset mid-operation: everything clears asynchronously and the fill sequence restarts. No pulse is generated for the 0 -> X jump during refill.
- Multi-bit source jumps (source advancing several counts between samples): legal. They are reported as a single ptr_chg_o with delta > 1.
- Input held constant: ptr_chg_o stays 0 and ptr_delta_o holds its last value.

Optional Feature:
- Macro: SYNC_PTR_GRAY_CHECK_EN.
- Defined:
  - A register holds the previous ptr_gray_o.
  - When sync_vld_o=1 and popcount(ptr_gray_o ^ prev) > 1, gray_err_o sets on the next edge.
  - gray_err_o is sticky until err_clr_i=1 is sampled.
  - If set and clear occur in the same cycle, set wins.
  - err_clr_i has no effect while drst_ni=0.
- Not defined: gray_err_o is tied to 0, err_clr_i is ignored, and there is no extra register or comparator.

Decomposition:
- Package sync_pkg:
  - function gray2bin, parameterised by width
  - function popcount
  - localparams SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=6
- One sub-module: sync_chain (WIDTH, STAGES). A pure N-stage flop chain with asynchronous active-low reset to 0, also reusable for single-bit flags.
- sync_ptr_gray instantiates one sync_chain and implements the decode, delta, fill and check logic itself.

Test Plan:
- Reset then hold ptr_gray_i=0, STAGES=2: sync_vld_o rises on the 3rd edge after release. ptr_chg_o never pulses; ptr_bin_o=0 and ptr_delta_o=0 throughout.
- After valid, step ptr_gray_i through the Gray sequence 0,1,3,2 one count every 4 cycles: each step appears on ptr_bin_o 3 edges later as 1,2,3. Each step gives one ptr_chg_o pulse with ptr_delta_o=1.
- ADDRSIZE=4: drive Gray(30) then Gray(2) (skip over the wrap): ptr_bin_o goes 30 -> 2, with one ptr_chg_o pulse and ptr_delta_o=4.
- STAGES=4: drive Gray(5) and hold: ptr_bin_o=5 exactly 5 edges after sampling, and sync_vld_o first rises on the 5th edge after reset.
- Assert drst_ni low mid-stream while ptr_bin_o=9: all outputs go to 0 immediately. After release with the input at Gray(9), ptr_bin_o returns to 9 with no ptr_chg_o pulse before sync_vld_o.
- With SYNC_PTR_GRAY_CHECK_EN defined, jump the input 0 -> 3'b101 pattern (2 bits changed): gray_err_o sets and stays set. Pulse err_clr_i together with another 2-bit jump: gray_err_o stays 1. A clean err_clr_i then clears it. Without the macro, gray_err_o stays 0.
